axi_sim_burst_mem: RTL and testbench

//  AXI4 slave memory: parametrised data width, depth, ID width and read latency; INCR bursts with per-byte strobes.

---
 rtl/axi_sim_burst_mem_if.sv | 67 ++++++
 rtl/axi_sim_burst_mem.sv | 250 +++++++++++++++++++++++++
 tb/tb_axi_sim_burst_mem.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sim_burst_mem_if.sv
// AXI4 channel bundle for axi_sim_burst_mem: AW/W/B/AR/R signals with
// master (requester) and slave (memory) modports. Clock and reset stay
// outside the bundle as plain module ports.
interface axi_sim_burst_mem_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
);
    localparam int unsigned BPW = DATA_WIDTH / 8;

    // write address channel
    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic                  aw_valid;
    logic                  aw_ready;
    // write data channel
    logic [DATA_WIDTH-1:0] w_data;
    logic [BPW-1:0]        w_strb;
    logic                  w_last;
    logic                  w_valid;
    logic                  w_ready;
    // write response channel
    logic [ID_WIDTH-1:0]   b_id;
    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  b_ready;
    // read address channel
    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic                  ar_valid;
    logic                  ar_ready;
    // read data channel
    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic                  r_valid;
    logic                  r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_sim_burst_mem.sv
// AXI4 slave memory with INCR bursts, per-byte write strobes and a
// configurable read latency. Independent write and read state machines.
// Optional feature macro: AXI_MEM_RANGE_CHECK_EN -- when defined, beats
// addressing at or beyond MEM_BYTES are dropped (write) or return zero
// (read) with SLVERR; otherwise addresses wrap modulo MEM_BYTES.
// The interface parameters must match ADDR_WIDTH/DATA_WIDTH/ID_WIDTH here.
module axi_sim_burst_mem #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MEM_BYTES  = 1024,
    parameter int unsigned RD_LATENCY = 1
) (
    input logic                clk,
    input logic                rst_n,
    axi_sim_burst_mem_if.slave bus
);
    localparam int unsigned BPW      = DATA_WIDTH / 8;
    localparam int unsigned OFF_BITS = $clog2(BPW);
    localparam int unsigned MEM_BITS = $clog2(MEM_BYTES);
    localparam int unsigned WORDS    = MEM_BYTES / BPW;
    localparam int unsigned IDX_BITS = MEM_BITS - OFF_BITS;
    localparam int unsigned IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int unsigned LAT_W    = $clog2(RD_LATENCY) + 1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BPW);
    localparam logic [LAT_W-1:0]      LAT_INIT  = LAT_W'(RD_LATENCY - 1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // word index: drop the byte-offset bits, wrap modulo the capacity
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        if (IDX_BITS == 0) return '0;
        return IDX_W'(a >> OFF_BITS);
    endfunction

`ifdef AXI_MEM_RANGE_CHECK_EN
    function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
        return |(a >> MEM_BITS);
    endfunction
`endif

    // ------------------------------------------------------------------
    // write side
    // ------------------------------------------------------------------
    w_state_t              w_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [7:0]            w_beat;
    logic                  w_err;
    logic [ID_WIDTH-1:0]   b_id_q;
    logic [1:0]            b_resp_q;
    logic                  aw_hs, w_hs, w_final, w_beat_err, w_oor, mem_we;

`ifdef AXI_MEM_RANGE_CHECK_EN
    assign w_oor = addr_oor(w_addr);
`else
    assign w_oor = 1'b0;
`endif

    // write FSM next state and handshake decode
    always_comb begin
        w_state_nxt = w_state;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        mem_we      = 1'b0;
        w_final     = (w_beat == w_len);
        // burst length comes from aw_len; w_last is only checked, never trusted
        w_beat_err  = (bus.w_last != w_final) | w_oor;
        case (w_state)
            W_IDLE: begin
                if (bus.aw_valid) begin
                    aw_hs       = 1'b1;
                    w_state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                if (bus.w_valid) begin
                    w_hs   = 1'b1;
                    mem_we = !w_oor;
                    if (w_final) w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (bus.b_ready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // write FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_state_nxt;
    end

    // write burst address/count tracking and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_addr   <= '0;
            w_len    <= '0;
            w_beat   <= '0;
            w_err    <= 1'b0;
            b_id_q   <= '0;
            b_resp_q <= '0;
        end else begin
            if (aw_hs) begin
                w_addr <= bus.aw_addr;
                w_len  <= bus.aw_len;
                w_beat <= '0;
                w_err  <= 1'b0;
                b_id_q <= bus.aw_id;
            end
            if (w_hs) begin
                w_addr <= w_addr + ADDR_STEP;
                w_beat <= w_beat + 8'd1;
                w_err  <= w_err | w_beat_err;
                if (w_final) b_resp_q <= (w_err | w_beat_err) ? 2'b10 : 2'b00;
            end
        end
    end

    // byte-enabled array write; storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < BPW; b++) begin
                if (bus.w_strb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= bus.w_data[b*8 +: 8];
            end
        end
    end

    assign bus.aw_ready = (w_state == W_IDLE);
    assign bus.w_ready  = (w_state == W_DATA);
    assign bus.b_valid  = (w_state == W_RESP);
    assign bus.b_id     = b_id_q;
    assign bus.b_resp   = b_resp_q;

    // ------------------------------------------------------------------
    // read side
    // ------------------------------------------------------------------
    r_state_t              r_state, r_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_beat;
    logic [LAT_W-1:0]      r_lat;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [1:0]            r_resp_q;
    logic                  r_last_q;
    logic                  ar_hs, r_hs, r_load, ld_oor;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [7:0]            ld_beat, ld_len;

`ifdef AXI_MEM_RANGE_CHECK_EN
    assign ld_oor = addr_oor(ld_addr);
`else
    assign ld_oor = 1'b0;
`endif

    // read FSM next state; decides when the next beat is loaded from the array.
    // With RD_LATENCY==1 the first beat loads on the AR handshake edge itself.
    always_comb begin
        r_state_nxt = r_state;
        ar_hs       = 1'b0;
        r_hs        = 1'b0;
        r_load      = 1'b0;
        ld_addr     = r_addr;
        ld_beat     = r_beat + 8'd1;
        ld_len      = r_len;
        case (r_state)
            R_IDLE: begin
                if (bus.ar_valid) begin
                    ar_hs   = 1'b1;
                    ld_addr = bus.ar_addr;
                    ld_beat = '0;
                    ld_len  = bus.ar_len;
                    if (RD_LATENCY == 1) begin
                        r_load      = 1'b1;
                        r_state_nxt = R_DATA;
                    end else begin
                        r_state_nxt = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                ld_beat = '0;
                if (r_lat == LAT_W'(1)) begin
                    r_load      = 1'b1;
                    r_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                if (bus.r_ready) begin
                    r_hs = 1'b1;
                    if (r_last_q) r_state_nxt = R_IDLE;
                    else          r_load      = 1'b1;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // read FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_state_nxt;
    end

    // read burst tracking and beat register (holds while stalled)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_lat    <= '0;
            r_id_q   <= '0;
            r_data_q <= '0;
            r_resp_q <= '0;
            r_last_q <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_addr <= bus.ar_addr;
                r_len  <= bus.ar_len;
                r_id_q <= bus.ar_id;
                r_lat  <= LAT_INIT;
            end else if (r_state == R_WAIT) begin
                r_lat <= r_lat - LAT_W'(1);
            end
            if (r_hs && r_last_q) r_last_q <= 1'b0;
            if (r_load) begin
                r_addr   <= ld_addr + ADDR_STEP;
                r_beat   <= ld_beat;
                r_last_q <= (ld_beat == ld_len);
                r_data_q <= ld_oor ? '0 : mem[word_idx(ld_addr)];
                r_resp_q <= ld_oor ? 2'b10 : 2'b00;
            end
        end
    end

    assign bus.ar_ready = (r_state == R_IDLE);
    assign bus.r_valid  = (r_state == R_DATA);
    assign bus.r_id     = r_id_q;
    assign bus.r_data   = r_data_q;
    assign bus.r_resp   = r_resp_q;
    assign bus.r_last   = r_last_q;

endmodule

// File: tb/tb_axi_sim_burst_mem.sv
// Self-checking bench for axi_sim_burst_mem: byte-array reference model,
// directed scenarios plus randomized bursts with random back-pressure.
module tb_axi_sim_burst_mem;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IW  = 4;
    localparam int MB  = 1024;
    localparam int RL  = 1;
    localparam int BPW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_sim_burst_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    axi_sim_burst_mem #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_BYTES(MB), .RD_LATENCY(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // reference model: plain byte array
    logic [7:0]     exp_mem [MB];
    // write stimulus buffers
    logic [DW-1:0]  wbuf [256];
    logic [BPW-1:0] sbuf [256];
    logic           lbuf [256];
    // captured read beats
    logic [DW-1:0]  rd_data [256];
    logic [1:0]     rd_resp [256];
    logic           rd_last [256];
    logic [IW-1:0]  rd_id   [256];
    int             rd_lat, rd_unstable, rd_gaps, rd_n;
    logic           rd_valid_after;

    function automatic logic beat_oor(input logic [AW-1:0] a);
`ifdef AXI_MEM_RANGE_CHECK_EN
        return a >= AW'(MB);
`else
        return (a != a);
`endif
    endfunction

    function automatic int unsigned byte_base(input logic [AW-1:0] a);
        int unsigned u;
        u = a % MB;
        return (u / BPW) * BPW;
    endfunction

    function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = '0;
        if (beat_oor(a)) return w;
        for (int b = 0; b < BPW; b++) w[b*8 +: 8] = exp_mem[byte_base(a) + b];
        return w;
    endfunction

    function automatic void model_write(input logic [AW-1:0] addr, input int len);
        logic [AW-1:0] a;
        for (int i = 0; i <= len; i++) begin
            a = addr + AW'(i * BPW);
            if (!beat_oor(a))
                for (int b = 0; b < BPW; b++)
                    if (sbuf[i][b]) exp_mem[byte_base(a) + b] = wbuf[i][b*8 +: 8];
        end
    endfunction

    function automatic logic [1:0] exp_bresp(input logic [AW-1:0] addr, input int len);
        logic err;
        err = 1'b0;
        for (int i = 0; i <= len; i++)
            if (lbuf[i] != (i == len) || beat_oor(addr + AW'(i * BPW))) err = 1'b1;
        return err ? 2'b10 : 2'b00;
    endfunction

    // drive one write burst from wbuf/sbuf/lbuf, return the B response
    task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                            output logic [IW-1:0] bid, output logic [1:0] bresp, output int bunst);
        int n;
        bunst = 0;
        @(negedge clk);
        bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = 8'(len); bus.aw_valid = 1'b1;
        n = 0;
        while (!bus.aw_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus.aw_ready) begin checks++; errors++; $display("FAIL aw_timeout got=0 want=1"); end
        @(negedge clk);
        bus.aw_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            while ($urandom_range(0, 3) == 0) begin bus.w_valid = 1'b0; @(negedge clk); end
            bus.w_valid = 1'b1; bus.w_data = wbuf[i]; bus.w_strb = sbuf[i]; bus.w_last = lbuf[i];
            n = 0;
            while (!bus.w_ready && n < 200) begin @(negedge clk); n++; end
            if (!bus.w_ready) begin checks++; errors++; $display("FAIL w_timeout beat=%0d", i); end
            @(negedge clk);
        end
        bus.w_valid = 1'b0; bus.w_last = 1'b0;
        n = 0;
        while (!bus.b_valid && n < 200) begin @(negedge clk); n++; end
        if (!bus.b_valid) begin checks++; errors++; $display("FAIL b_timeout got=0 want=1"); end
        bid = bus.b_id; bresp = bus.b_resp;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            if (!bus.b_valid || bus.b_id !== bid || bus.b_resp !== bresp) bunst++;
        end
        bus.b_ready = 1'b1;
        @(negedge clk);
        bus.b_ready = 1'b0;
    endtask

    // drive one read burst; mode 0 always ready, 1 alternating 1,0,..., 2 random
    task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len, input int mode);
        int n, k, beat;
        logic rdy, stalled;
        logic [DW-1:0] hd; logic [1:0] hr; logic hl; logic [IW-1:0] hi;
        rd_unstable = 0; rd_gaps = 0; rd_n = 0;
        hd = '0; hr = '0; hl = 1'b0; hi = '0;
        @(negedge clk);
        bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = 8'(len); bus.ar_valid = 1'b1; bus.r_ready = 1'b0;
        n = 0;
        while (!bus.ar_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus.ar_ready) begin checks++; errors++; $display("FAIL ar_timeout got=0 want=1"); end
        @(negedge clk);
        bus.ar_valid = 1'b0;
        rd_lat = 1; n = 0;
        while (!bus.r_valid && n < 200) begin @(negedge clk); rd_lat++; n++; end
        if (!bus.r_valid) begin checks++; errors++; $display("FAIL r_timeout got=0 want=1"); end
        k = 0; beat = 0; stalled = 1'b0;
        while (beat <= len && n < 3000) begin
            if (bus.r_valid) begin
                if (stalled && (bus.r_data !== hd || bus.r_resp !== hr || bus.r_last !== hl || bus.r_id !== hi))
                    rd_unstable++;
                rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
                k++;
                bus.r_ready = rdy;
                if (rdy) begin
                    rd_data[beat] = bus.r_data; rd_resp[beat] = bus.r_resp;
                    rd_last[beat] = bus.r_last; rd_id[beat] = bus.r_id;
                    beat++; stalled = 1'b0;
                end else begin
                    hd = bus.r_data; hr = bus.r_resp; hl = bus.r_last; hi = bus.r_id; stalled = 1'b1;
                end
            end else begin
                bus.r_ready = 1'b0;
                rd_gaps++;
            end
            @(negedge clk);
            n++;
        end
        bus.r_ready = 1'b0;
        rd_n = beat;
        rd_valid_after = bus.r_valid;
        if (beat <= len) begin checks++; errors++; $display("FAIL r_beats_timeout got=%0d want=%0d", beat, len + 1); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.aw_ready !== 1'b1 || bus.ar_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b%b want=11", bus.aw_ready, bus.ar_ready); end
        checks++; if ({bus.w_ready, bus.b_valid, bus.r_valid, bus.r_last} !== 4'b0000) begin errors++; $display("FAIL reset_valids got=%b want=0000", {bus.w_ready, bus.b_valid, bus.r_valid, bus.r_last}); end
        checks++; if ({bus.b_resp, bus.r_resp, bus.b_id, bus.r_id} !== '0 || bus.r_data !== '0) begin errors++; $display("FAIL reset_regs got=%h/%h want=0/0", {bus.b_resp, bus.r_resp, bus.b_id, bus.r_id}, bus.r_data); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({bus.aw_ready, bus.ar_ready, bus.w_ready, bus.b_valid, bus.r_valid} !== 5'b11000) begin errors++; $display("FAIL release_state got=%b want=11000", {bus.aw_ready, bus.ar_ready, bus.w_ready, bus.b_valid, bus.r_valid}); end
    endtask

    task automatic test_fill;
        logic [IW-1:0] bid; logic [1:0] br; int bu;
        for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = '1; lbuf[i] = (i == 255); end
        do_write(4'd9, '0, 255, bid, br, bu);
        model_write('0, 255);
        checks++; if (br !== 2'b00 || bid !== 4'd9) begin errors++; $display("FAIL fill_b got=%b/%h want=00/9", br, bid); end
        checks++; if (bu !== 0) begin errors++; $display("FAIL fill_b_stable got=%0d want=0", bu); end
        do_read(4'd2, '0, 255, 2);
        for (int i = 0; i < rd_n; i++) begin
            checks++;
            if (rd_data[i] !== exp_word(AW'(i * BPW)) || rd_last[i] !== (i == 255) || rd_resp[i] !== 2'b00) begin
                errors++; $display("FAIL fill_beat%0d got=%h/%b want=%h/%b", i, rd_data[i], rd_last[i], exp_word(AW'(i * BPW)), (i == 255));
            end
        end
        checks++; if (rd_unstable !== 0 || rd_gaps !== 0) begin errors++; $display("FAIL fill_r_stable got=%0d/%0d want=0/0", rd_unstable, rd_gaps); end
    endtask

    task automatic test_strobe;
        logic [IW-1:0] bid; logic [1:0] br; int bu;
        wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'b1111; lbuf[0] = 1'b1;
        do_write(4'd1, 32'h10, 0, bid, br, bu); model_write(32'h10, 0);
        wbuf[0] = 32'hDEAD_BEEF; sbuf[0] = 4'b0011; lbuf[0] = 1'b1;
        do_write(4'd1, 32'h10, 0, bid, br, bu); model_write(32'h10, 0);
        do_read(4'd3, 32'h10, 0, 0);
        checks++; if (rd_data[0] !== 32'hFFFF_BEEF) begin errors++; $display("FAIL strobe_data got=%h want=ffffbeef", rd_data[0]); end
        checks++; if (rd_last[0] !== 1'b1 || rd_id[0] !== 4'd3 || rd_resp[0] !== 2'b00) begin errors++; $display("FAIL strobe_attr got=%b/%h/%b want=1/3/00", rd_last[0], rd_id[0], rd_resp[0]); end
        checks++; if (rd_lat !== RL) begin errors++; $display("FAIL strobe_latency got=%0d want=%0d", rd_lat, RL); end
        checks++; if (rd_valid_after !== 1'b0) begin errors++; $display("FAIL strobe_r_idle got=%b want=0", rd_valid_after); end
    endtask

    task automatic test_incr_burst;
        logic [IW-1:0] bid; logic [1:0] br; int bu;
        for (int i = 0; i < 4; i++) begin wbuf[i] = DW'(i + 1); sbuf[i] = '1; lbuf[i] = (i == 3); end
        do_write(4'd5, 32'h100, 3, bid, br, bu); model_write(32'h100, 3);
        checks++; if (bid !== 4'd5 || br !== 2'b00) begin errors++; $display("FAIL incr_b got=%h/%b want=5/00", bid, br); end
        do_read(4'd6, 32'h100, 3, 1);
        for (int i = 0; i < rd_n; i++) begin
            checks++;
            if (rd_data[i] !== DW'(i + 1) || rd_last[i] !== (i == 3) || rd_id[i] !== 4'd6) begin
                errors++; $display("FAIL incr_beat%0d got=%h/%b/%h want=%h/%b/6", i, rd_data[i], rd_last[i], rd_id[i], i + 1, (i == 3));
            end
        end
        checks++; if (rd_unstable !== 0 || rd_gaps !== 0) begin errors++; $display("FAIL incr_stall_stable got=%0d/%0d want=0/0", rd_unstable, rd_gaps); end
    endtask

    task automatic test_last_mismatch;
        logic [IW-1:0] bid; logic [1:0] br; int bu;
        for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = '1; lbuf[i] = (i == 1); end
        do_write(4'd7, 32'h180, 3, bid, br, bu); model_write(32'h180, 3);
        checks++; if (br !== 2'b10 || bid !== 4'd7) begin errors++; $display("FAIL early_last_b got=%b/%h want=10/7", br, bid); end
        do_read(4'd7, 32'h180, 3, 0);
        for (int i = 0; i < rd_n; i++) begin
            checks++; if (rd_data[i] !== wbuf[i]) begin errors++; $display("FAIL early_last_data%0d got=%h want=%h", i, rd_data[i], wbuf[i]); end
        end
        wbuf[0] = $urandom; sbuf[0] = '1; lbuf[0] = 1'b0;
        do_write(4'd8, 32'h1C0, 0, bid, br, bu); model_write(32'h1C0, 0);
        checks++; if (br !== 2'b10) begin errors++; $display("FAIL missing_last_b got=%b want=10", br); end
    endtask

    task automatic test_wrap;
        logic [IW-1:0] bid; logic [1:0] br; int bu;
        wbuf[0] = 32'hA5A5_0001; sbuf[0] = '1; lbuf[0] = 1'b1;
        do_write(4'd0, 32'h0, 0, bid, br, bu); model_write(32'h0, 0);
        do_read(4'd4, 32'h400, 0, 0);
`ifdef AXI_MEM_RANGE_CHECK_EN
        checks++; if (rd_data[0] !== '0 || rd_resp[0] !== 2'b10) begin errors++; $display("FAIL oor_read got=%h/%b want=0/10", rd_data[0], rd_resp[0]); end
`else
        checks++; if (rd_data[0] !== 32'hA5A5_0001 || rd_resp[0] !== 2'b00) begin errors++; $display("FAIL wrap_read got=%h/%b want=a5a50001/00", rd_data[0], rd_resp[0]); end
`endif
        for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = '1; lbuf[i] = (i == 3); end
        do_write(4'd2, 32'h3F8, 3, bid, br, bu); model_write(32'h3F8, 3);
        checks++; if (br !== exp_bresp(32'h3F8, 3)) begin errors++; $display("FAIL edge_write_b got=%b want=%b", br, exp_bresp(32'h3F8, 3)); end
        do_read(4'd2, 32'h3F8, 3, 2);
        for (int i = 0; i < rd_n; i++) begin
            checks++;
            if (rd_data[i] !== exp_word(32'h3F8 + AW'(i * BPW)) || rd_resp[i] !== (beat_oor(32'h3F8 + AW'(i * BPW)) ? 2'b10 : 2'b00)) begin
                errors++; $display("FAIL edge_read%0d got=%h/%b want=%h", i, rd_data[i], rd_resp[i], exp_word(32'h3F8 + AW'(i * BPW)));
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bus.aw_id = 4'd3; bus.aw_addr = 32'h40; bus.aw_len = 8'd3; bus.aw_valid = 1'b1;
        @(negedge clk);
        bus.aw_valid = 1'b0;
        wbuf[0] = 32'h1234_5678; sbuf[0] = '1; lbuf[0] = 1'b0;
        bus.w_valid = 1'b1; bus.w_data = wbuf[0]; bus.w_strb = sbuf[0]; bus.w_last = 1'b0;
        @(negedge clk);
        model_write(32'h40, 0);
        bus.w_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({bus.aw_ready, bus.w_ready, bus.b_valid} !== 3'b100) begin errors++; $display("FAIL midreset_state got=%b want=100", {bus.aw_ready, bus.w_ready, bus.b_valid}); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (bus.b_valid !== 1'b0 || bus.w_ready !== 1'b0) begin errors++; $display("FAIL midreset_noresp got=%b%b want=00", bus.b_valid, bus.w_ready); end
        do_read(4'd1, 32'h40, 0, 0);
        checks++; if (rd_data[0] !== 32'h1234_5678) begin errors++; $display("FAIL midreset_beat got=%h want=12345678", rd_data[0]); end
    endtask

    task automatic test_random;
        logic [IW-1:0] bid, id; logic [1:0] br, eb; int bu, len; logic [AW-1:0] addr, a;
        for (int t = 0; t < 30; t++) begin
            addr = AW'($urandom_range(0, MB - 1));
            len  = $urandom_range(0, 15);
            id   = IW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) begin wbuf[i] = $urandom; sbuf[i] = BPW'($urandom); lbuf[i] = (i == len); end
                if ($urandom_range(0, 5) == 0) lbuf[len] = 1'b0;
                eb = exp_bresp(addr, len);
                do_write(id, addr, len, bid, br, bu);
                model_write(addr, len);
                checks++; if (br !== eb || bid !== id || bu !== 0) begin errors++; $display("FAIL rnd_write%0d got=%b/%h/%0d want=%b/%h/0", t, br, bid, bu, eb, id); end
            end else begin
                do_read(id, addr, len, 2);
                for (int i = 0; i < rd_n; i++) begin
                    a = addr + AW'(i * BPW);
                    checks++;
                    if (rd_data[i] !== exp_word(a) || rd_last[i] !== (i == len) || rd_id[i] !== id || rd_resp[i] !== (beat_oor(a) ? 2'b10 : 2'b00)) begin
                        errors++; $display("FAIL rnd_read%0d_beat%0d got=%h/%b/%h want=%h/%b/%h", t, i, rd_data[i], rd_last[i], rd_id[i], exp_word(a), (i == len), id);
                    end
                end
                checks++; if (rd_unstable !== 0 || rd_gaps !== 0 || rd_lat !== RL) begin errors++; $display("FAIL rnd_read%0d_timing got=%0d/%0d/%0d want=0/0/%0d", t, rd_unstable, rd_gaps, rd_lat, RL); end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [IW-1:0] bid; logic [1:0] br; int bu;
        logic [DW-1:0] exp_rd [8];
        for (int i = 0; i < 8; i++) begin
            exp_rd[i] = exp_word(AW'(i * BPW));
            wbuf[i] = $urandom; sbuf[i] = '1; lbuf[i] = (i == 7);
        end
        fork
            do_write(4'hA, 32'h200, 7, bid, br, bu);
            do_read(4'hB, 32'h000, 7, 2);
        join
        model_write(32'h200, 7);
        checks++; if (br !== 2'b00 || bid !== 4'hA) begin errors++; $display("FAIL overlap_b got=%b/%h want=00/a", br, bid); end
        for (int i = 0; i < rd_n; i++) begin
            checks++; if (rd_data[i] !== exp_rd[i] || rd_id[i] !== 4'hB) begin errors++; $display("FAIL overlap_read%0d got=%h want=%h", i, rd_data[i], exp_rd[i]); end
        end
        do_read(4'hC, 32'h200, 7, 0);
        for (int i = 0; i < rd_n; i++) begin
            checks++; if (rd_data[i] !== wbuf[i]) begin errors++; $display("FAIL overlap_wdata%0d got=%h want=%h", i, rd_data[i], wbuf[i]); end
        end
    endtask

    initial begin
        bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_valid = 1'b0;
        bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_valid = 1'b0;
        bus.b_ready = 1'b0;
        bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_valid = 1'b0;
        bus.r_ready = 1'b0;
        test_reset();
        test_fill();
        test_strobe();
        test_incr_burst();
        test_last_mismatch();
        test_wrap();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
